spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder for the team's SPI master; it is the other end of the same 4-wire link.
- Oversamples the external SCLK/SS_n/MOSI in the system clock domain, shifts WORD_WIDTH-bit words MSB-first and drives MISO.
- Exchanges words with the local core through a one-entry TX buffer (valid/ready) and an RX holding register (valid/ready).
- Used for board-to-board links and as the loopback partner of the master in integration benches.

Parameters:
- WORD_WIDTH, 8: bits per SPI word, ≥2.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- sclk_i  in  1  SPI clock from master, asynchronous.
- ss_n_i  in  1  slave select, active-low, asynchronous.
- mosi_i  in  1  master-out data, asynchronous.
- miso_o  out  1  slave-out data.
- tx_data_i  in  WORD_WIDTH  next word to send.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  TX buffer empty; a write is accepted when valid&ready.
- rx_data_o  out  WORD_WIDTH  last received word.
- rx_valid_o  out  1  rx_data_o holds an unread word.
- rx_ready_i  in  1  core consumes rx_data_o when valid&ready.
- busy_o  out  1  frame active (synchronized SS low).
- overrun_o  out  1  1-cycle pulse: a completed word overwrote an unread word.
- underrun_o  out  1  1-cycle pulse: a word load found the TX buffer empty; zeros are sent.

Behaviour:
- Reset values:
  - miso_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, overrun_o=0, underrun_o=0.
  - Shift registers, bit counter and TX buffer are cleared; state is IDLE.
- Synchronization:
  - Each of sclk_i, ss_n_i and mosi_i passes through 2 flops.
  - Edges are detected on the synchronized sclk/ss: 1-cycle pulses, 3 clk_i cycles after the pin changes.
  - Requirement: f_clk_i ≥ 8×f_sclk.
- Edge definition: leading edge = sclk leaves CPOL; trailing edge = sclk returns to CPOL.
- States:
  - IDLE:
    - Synchronized SS falling edge → ACTIVE, busy_o=1.
    - Same cycle: the word load runs (see Word load).
  - ACTIVE, CPHA=0:
    - Leading edge: sample mosi into rx_shift, bit_cnt++.
    - Trailing edge: shift tx_shift left, unless bit_cnt==WORD_WIDTH, in which case do a word load.
  - ACTIVE, CPHA=1:
    - Leading edge: shift tx_shift left, except on the first leading edge of each word (MSB is already presented).
    - Trailing edge: sample mosi, bit_cnt++.
    - At bit_cnt==WORD_WIDTH: word complete, then word load.
  - Any synchronized SS rising edge → IDLE, busy_o=0, miso_o=0.
    - A partial word is discarded: no rx_valid_o, bit_cnt=0.
    - The TX buffer contents are kept.
  - A reset is treated as an SS rise; after reset the block waits for SS high before it accepts an SS fall.
- miso_o = tx_shift[MSB] while ACTIVE, 0 in IDLE. It is registered and updates in the cycle after the load or shift.
- Word load:
  - If the TX buffer is full: tx_shift ← buffer, buffer emptied, tx_ready_o=1 next cycle.
  - Else: tx_shift ← 0 and underrun_o pulses.
  - A buffer write in the same cycle as a load is not seen by that load; it fills the buffer for the next word.
- Word complete:
  - rx_data_o ← assembled word (last bit included), rx_valid_o=1 next cycle.
  - If rx_valid_o was already 1 and rx_ready_i=0: the word is overwritten and overrun_o pulses.
  - Completion and rx_ready_i in the same cycle: new data is shown, rx_valid_o stays 1, no overrun.
- bit_cnt wraps to 0 at each word boundary; frames of several words are back-to-back with no gap required.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, ACTIVE);
  - CPOL/CPHA mode constants;
  - shared by the master and the slave.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall pulse generator. Three instances (sclk, ss_n, mosi; the mosi instance has edges unused).

Test Plan:
- Mode 0, TX buffer holds 0xA5, master sends 0x3C → master receives 0xA5; rx_data_o=0x3C, rx_valid_o=1; no pulses.
- Mode 3 (CPOL=1, CPHA=1), two-word frame, buffer refilled after the first tx_ready_o (0x81, then 0x7E); master sends 0xF0, 0x0F → master gets 0x81, 0x7E; rx words 0xF0, 0x0F in order.
- No TX write before SS fall → underrun_o pulses once; master receives 0x00.
- Two words received with rx_ready_i held 0 → overrun_o pulses once; rx_data_o = second word.
- SS raised after 5 bits → busy_o=0, no rx_valid_o; the next full frame is received correctly.
- rst_i asserted mid-word with SS held low → all outputs at reset values; no activity until SS goes high then low again.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master/slave pair: link states, mode encodings
// and small helpers used by both ends of the link.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic CPOL_IDLE_LOW     = 1'b0;
  localparam logic CPOL_IDLE_HIGH    = 1'b1;
  localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

  // Bit counter must be able to hold the full word length itself.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  // Leading edge leaves the idle level: a rise for CPOL=0, a fall for CPOL=1.
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop that
// turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Advance the pin through two sync stages and one history stage.
  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/SS_n/MOSI in the clk_i domain, shifts
// MSB-first words and trades them with the core through TX/RX handshakes.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter logic        CPOL       = CPOL_IDLE_LOW,
  parameter logic        CPHA       = CPHA_SAMPLE_LEAD
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [WORD_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [WORD_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  underrun_o
);

  localparam int unsigned      CNT_W    = cnt_width(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_WIDTH);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic ss_lvl_s, ss_rise_s, ss_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic lead_s, trail_s;
  logic unused_sync_s;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
    .level_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  // SS sync resets low so an SS held low through reset never looks like a fall.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_ss (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ss_n_i),
    .level_o(ss_lvl_s), .rise_o(ss_rise_s), .fall_o(ss_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
    .level_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
  );

  assign unused_sync_s = ^{sclk_lvl_s, ss_lvl_s, mosi_rise_s, mosi_fall_s};
  assign lead_s        = lead_edge(CPOL, sclk_rise_s, sclk_fall_s);
  assign trail_s       = trail_edge(CPOL, sclk_rise_s, sclk_fall_s);

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  first_lead_q, first_lead_d;
  logic                  und_pend_q, und_pend_d;
  logic                  do_sample_s, do_shift_s, do_load_s;

  // Next-state logic: frame control, sampling, shifting, word loads and handshakes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    busy_d       = busy_q;
    first_lead_d = first_lead_q;
    und_pend_d   = und_pend_q;
    overrun_d    = 1'b0;
    underrun_d   = 1'b0;
    do_sample_s  = 1'b0;
    do_shift_s   = 1'b0;
    do_load_s    = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d      = ST_ACTIVE;
          busy_d       = 1'b1;
          bit_cnt_d    = CNT_ZERO;
          first_lead_d = 1'b1;
          do_load_s    = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_s) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          bit_cnt_d  = CNT_ZERO;
          und_pend_d = 1'b0;
        end else if (CPHA == CPHA_SAMPLE_LEAD) begin
          if (lead_s) begin
            do_sample_s = 1'b1;
          end else if (trail_s) begin
            do_load_s  = (bit_cnt_q == FULL_CNT);
            do_shift_s = (bit_cnt_q != FULL_CNT);
          end else begin
            do_sample_s = 1'b0;
          end
        end else begin
          if (lead_s) begin
            do_shift_s   = ~first_lead_q;
            first_lead_d = 1'b0;
          end else if (trail_s) begin
            do_sample_s = 1'b1;
          end else begin
            do_sample_s = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Underrun is reported when the zero word is actually clocked, so the
    // speculative load after a frame's last word stays silent.
    if (do_sample_s) begin
      rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + CNT_ONE;
      if (bit_cnt_q == CNT_ZERO) begin
        underrun_d = und_pend_q;
        und_pend_d = 1'b0;
      end else begin
        underrun_d = 1'b0;
      end
      if (bit_cnt_q == LAST_BIT) begin
        rx_data_d  = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
        rx_valid_d = 1'b1;
        overrun_d  = rx_valid_q & ~rx_ready_i;
        if (CPHA == CPHA_SAMPLE_TRAIL) begin
          bit_cnt_d    = CNT_ZERO;
          first_lead_d = 1'b1;
          do_load_s    = 1'b1;
        end else begin
          first_lead_d = first_lead_q;
        end
      end else begin
        rx_data_d = rx_data_q;
      end
    end else begin
      rx_shift_d = rx_shift_q;
    end

    tx_ready_d = tx_ready_q;
    if (do_load_s) begin
      if (CPHA == CPHA_SAMPLE_LEAD) begin
        bit_cnt_d = CNT_ZERO;
      end else begin
        bit_cnt_d = bit_cnt_d;
      end
      if (!tx_ready_q) begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
        und_pend_d = 1'b0;
      end else begin
        tx_shift_d = {WORD_WIDTH{1'b0}};
        und_pend_d = 1'b1;
      end
    end else if (do_shift_s) begin
      tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
    end

    // A write only lands in an empty buffer; a load in the same cycle used the old contents.
    if (tx_valid_i && tx_ready_q) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end else begin
      tx_buf_d = tx_buf_q;
    end

    miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[WORD_WIDTH-1] : 1'b0;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= CNT_ZERO;
      rx_shift_q   <= {WORD_WIDTH{1'b0}};
      tx_shift_q   <= {WORD_WIDTH{1'b0}};
      tx_buf_q     <= {WORD_WIDTH{1'b0}};
      rx_data_q    <= {WORD_WIDTH{1'b0}};
      tx_ready_q   <= 1'b1;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      first_lead_q <= 1'b1;
      und_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_buf_q     <= tx_buf_d;
      rx_data_q    <= rx_data_d;
      tx_ready_q   <= tx_ready_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      first_lead_q <= first_lead_d;
      und_pend_q   <= und_pend_d;
    end
  end

  assign miso_o     = miso_q;
  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: index 0 is a mode-0 responder, index 1 a
// mode-3 responder; the bench plays the SPI master for both.
module tb_spi_slave;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk [2];
  logic       ss_n [2];
  logic       mosi [2];
  logic       miso [2];
  logic [7:0] tx_data [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic [7:0] rx_data [2];
  logic       rx_valid [2];
  logic       rx_ready [2];
  logic       busy [2];
  logic       ovr [2];
  logic       und [2];

  int n_vec = 0;
  int n_err = 0;
  int ovr_cnt [2] = '{0, 0};
  int und_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  spi_slave #(.WORD_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk[0]), .ss_n_i(ss_n[0]), .mosi_i(mosi[0]),
    .miso_o(miso[0]), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]),
    .rx_ready_i(rx_ready[0]), .busy_o(busy[0]), .overrun_o(ovr[0]), .underrun_o(und[0])
  );

  spi_slave #(.WORD_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk[1]), .ss_n_i(ss_n[1]), .mosi_i(mosi[1]),
    .miso_o(miso[1]), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]),
    .rx_ready_i(rx_ready[1]), .busy_o(busy[1]), .overrun_o(ovr[1]), .underrun_o(und[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (und[i] === 1'b1) und_cnt[i] <= und_cnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input int d, input logic [7:0] v);
    int n = 0;
    while (tx_ready[d] !== 1'b1 && n < 50) begin
      wait_clk(1);
      n++;
    end
    check_eq("tx_write_ready", 32'(tx_ready[d]), 32'd1);
    tx_data[d]  = v;
    tx_valid[d] = 1'b1;
    wait_clk(1);
    tx_valid[d] = 1'b0;
  endtask

  task automatic rx_consume(input int d);
    rx_ready[d] = 1'b1;
    wait_clk(1);
    rx_ready[d] = 1'b0;
    wait_clk(1);
  endtask

  task automatic ss_low(input int d);
    ss_n[d] = 1'b0;
    wait_clk(H);
  endtask

  task automatic ss_high(input int d);
    wait_clk(H);
    ss_n[d] = 1'b1;
    wait_clk(H);
  endtask

  // Master side: d=0 uses mode 0, d=1 uses mode 3; nbits from the MSB down.
  task automatic xfer(input int d, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic cpol;
    logic cpha;
    cpol = (d == 1);
    cpha = (d == 1);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[d] = tx[i];
        wait_clk(H);
        rx[i] = miso[d];
        sclk[d] = ~cpol;
        wait_clk(H);
        sclk[d] = cpol;
      end else begin
        sclk[d] = ~cpol;
        mosi[d] = tx[i];
        wait_clk(H);
        rx[i] = miso[d];
        sclk[d] = cpol;
        wait_clk(H);
      end
    end
  endtask

  initial begin
    logic [7:0] got;
    int o0;
    int u0;
    rst = 1'b1;
    sclk[0] = 1'b0;
    sclk[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ss_n[i] = 1'b1; mosi[i] = 1'b0; tx_data[i] = 8'h00;
      tx_valid[i] = 1'b0; rx_ready[i] = 1'b0;
    end
    wait_clk(4);
    check_eq("rst_miso0", 32'(miso[0]), 32'd0);
    check_eq("rst_tx_ready0", 32'(tx_ready[0]), 32'd1);
    check_eq("rst_rx_data0", 32'(rx_data[0]), 32'h00);
    check_eq("rst_rx_valid0", 32'(rx_valid[0]), 32'd0);
    check_eq("rst_busy0", 32'(busy[0]), 32'd0);
    check_eq("rst_ovr0", 32'(ovr[0]), 32'd0);
    check_eq("rst_und0", 32'(und[0]), 32'd0);
    check_eq("rst_tx_ready3", 32'(tx_ready[1]), 32'd1);
    check_eq("rst_busy3", 32'(busy[1]), 32'd0);
    rst = 1'b0;
    wait_clk(8);

    // Mode 0 single word exchange.
    tx_write(0, 8'hA5);
    o0 = ovr_cnt[0]; u0 = und_cnt[0];
    ss_low(0);
    check_eq("m0_busy", 32'(busy[0]), 32'd1);
    check_eq("m0_tx_ready_after_load", 32'(tx_ready[0]), 32'd1);
    xfer(0, 8'h3C, 8, got);
    ss_high(0);
    check_eq("m0_master_rx", 32'(got), 32'hA5);
    check_eq("m0_rx_data", 32'(rx_data[0]), 32'h3C);
    check_eq("m0_rx_valid", 32'(rx_valid[0]), 32'd1);
    check_eq("m0_busy_end", 32'(busy[0]), 32'd0);
    check_eq("m0_no_ovr", 32'(ovr_cnt[0] - o0), 32'd0);
    check_eq("m0_no_und", 32'(und_cnt[0] - u0), 32'd0);
    rx_consume(0);
    check_eq("m0_rx_consumed", 32'(rx_valid[0]), 32'd0);

    // Mode 3 two-word frame with buffer refill.
    tx_write(1, 8'h81);
    o0 = ovr_cnt[1]; u0 = und_cnt[1];
    ss_low(1);
    tx_write(1, 8'h7E);
    xfer(1, 8'hF0, 8, got);
    check_eq("m3_master_rx0", 32'(got), 32'h81);
    check_eq("m3_rx_data0", 32'(rx_data[1]), 32'hF0);
    check_eq("m3_rx_valid0", 32'(rx_valid[1]), 32'd1);
    rx_consume(1);
    xfer(1, 8'h0F, 8, got);
    ss_high(1);
    check_eq("m3_master_rx1", 32'(got), 32'h7E);
    check_eq("m3_rx_data1", 32'(rx_data[1]), 32'h0F);
    check_eq("m3_rx_valid1", 32'(rx_valid[1]), 32'd1);
    check_eq("m3_no_ovr", 32'(ovr_cnt[1] - o0), 32'd0);
    check_eq("m3_no_und", 32'(und_cnt[1] - u0), 32'd0);
    rx_consume(1);

    // Underrun: nothing written before the frame.
    o0 = ovr_cnt[0]; u0 = und_cnt[0];
    ss_low(0);
    xfer(0, 8'h55, 8, got);
    ss_high(0);
    check_eq("und_master_rx", 32'(got), 32'h00);
    check_eq("und_pulses", 32'(und_cnt[0] - u0), 32'd1);
    check_eq("und_rx_data", 32'(rx_data[0]), 32'h55);
    check_eq("und_no_ovr", 32'(ovr_cnt[0] - o0), 32'd0);
    rx_consume(0);

    // Overrun: two words, never consumed.
    o0 = ovr_cnt[0];
    ss_low(0);
    xfer(0, 8'h12, 8, got);
    xfer(0, 8'h34, 8, got);
    ss_high(0);
    check_eq("ovr_pulses", 32'(ovr_cnt[0] - o0), 32'd1);
    check_eq("ovr_rx_data", 32'(rx_data[0]), 32'h34);
    check_eq("ovr_rx_valid", 32'(rx_valid[0]), 32'd1);
    rx_consume(0);

    // Partial word discarded, following frame intact.
    ss_low(0);
    xfer(0, 8'hFF, 5, got);
    ss_high(0);
    check_eq("part_busy", 32'(busy[0]), 32'd0);
    check_eq("part_rx_valid", 32'(rx_valid[0]), 32'd0);
    tx_write(0, 8'h5A);
    ss_low(0);
    xfer(0, 8'hC3, 8, got);
    ss_high(0);
    check_eq("part_next_master_rx", 32'(got), 32'h5A);
    check_eq("part_next_rx_data", 32'(rx_data[0]), 32'hC3);
    check_eq("part_next_rx_valid", 32'(rx_valid[0]), 32'd1);
    rx_consume(0);

    // Reset mid-word with SS held low.
    tx_write(0, 8'h99);
    ss_low(0);
    tx_write(0, 8'h77);
    xfer(0, 8'hAA, 3, got);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check_eq("mrst_miso", 32'(miso[0]), 32'd0);
    check_eq("mrst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_eq("mrst_rx_data", 32'(rx_data[0]), 32'h00);
    check_eq("mrst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_eq("mrst_busy", 32'(busy[0]), 32'd0);
    o0 = ovr_cnt[0]; u0 = und_cnt[0];
    xfer(0, 8'hA5, 8, got);
    check_eq("mrst_idle_master_rx", 32'(got), 32'h00);
    check_eq("mrst_idle_busy", 32'(busy[0]), 32'd0);
    check_eq("mrst_idle_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_eq("mrst_idle_pulses", 32'((ovr_cnt[0] - o0) + (und_cnt[0] - u0)), 32'd0);
    ss_high(0);
    tx_write(0, 8'hE1);
    ss_low(0);
    xfer(0, 8'h66, 8, got);
    ss_high(0);
    check_eq("mrst_after_master_rx", 32'(got), 32'hE1);
    check_eq("mrst_after_rx_data", 32'(rx_data[0]), 32'h66);
    check_eq("mrst_after_rx_valid", 32'(rx_valid[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
